// File: rtl/aes_spi_responder.sv
// aes_spi_responder: SPI-side responder that shifts in data+key, runs the AES core and shifts the result out.
// Optional start marker on SDO before the result: define AES_SPI_RESP_START_BIT_EN.
module aes_spi_responder #(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              SDI,
  output logic              SDO,
  output logic              core_start,
  output logic [127:0]      core_data,
  output logic [Nk*32-1:0]  core_key,
  input  logic              core_done,
  input  logic [127:0]      core_result,
  output logic              busy,
  output logic              resp_done,
  output logic              frame_err
);
  localparam int KEY_W = Nk*32;
  localparam int RX_BITS = 128 + KEY_W;
  localparam int CW = $clog2(RX_BITS + 1);
`ifdef AES_SPI_RESP_START_BIT_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  localparam logic [CW-1:0] RX_LAST = CW'(RX_BITS - 1);
  localparam logic [CW-1:0] TX_LAST = SB ? CW'(128) : CW'(127);
  typedef enum logic [2:0] {S_IDLE, S_RX, S_START, S_WAIT, S_TX, S_DONE, S_HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RX_BITS-1:0] rx, rx_n, shift;
  logic [127:0] tx, tx_n, data_n;
  logic [KEY_W-1:0] key_n;
  logic sdo_n, start_n, done_n, err_n, abort;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      rx <= '0;
      tx <= '0;
      SDO <= 1'b0;
      core_start <= 1'b0;
      busy <= 1'b0;
      resp_done <= 1'b0;
      frame_err <= 1'b0;
      core_data <= '0;
      core_key <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rx <= rx_n;
      tx <= tx_n;
      SDO <= sdo_n;
      core_start <= start_n;
      busy <= state_n != S_IDLE;
      resp_done <= done_n;
      frame_err <= err_n;
      core_data <= data_n;
      core_key <= key_n;
    end
  end
  // Losing CS anywhere between first bit and last result bit kills the frame.
  assign abort = !CS && (state inside {S_RX, S_START, S_WAIT, S_TX});
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rx_n = rx;
    tx_n = tx;
    sdo_n = 1'b0;
    start_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    data_n = core_data;
    key_n = core_key;
    shift = {rx[RX_BITS-2:0], SDI};
    if (abort) begin
      state_n = S_IDLE;
      cnt_n = '0;
      err_n = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (CS) begin
          rx_n = shift;
          cnt_n = CW'(1);
          state_n = S_RX;
        end
        S_RX: begin
          rx_n = shift;
          cnt_n = cnt + CW'(1);
          if (cnt == RX_LAST) begin
            data_n = shift[RX_BITS-1:KEY_W];
            key_n = shift[KEY_W-1:0];
            start_n = 1'b1;
            state_n = S_START;
          end
        end
        S_START: state_n = S_WAIT;
        // Without the marker the MSB goes out on the capture edge itself.
        S_WAIT: if (core_done) begin
          tx_n = SB ? core_result : {core_result[126:0], 1'b0};
          sdo_n = SB | core_result[127];
          cnt_n = '0;
          state_n = S_TX;
        end
        S_TX: begin
          sdo_n = tx[127];
          tx_n = {tx[126:0], 1'b0};
          cnt_n = cnt + CW'(1);
          if (cnt == TX_LAST) begin
            sdo_n = 1'b0;
            done_n = 1'b1;
            state_n = S_DONE;
          end
        end
        S_DONE: state_n = S_HOLD;
        S_HOLD: if (!CS) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_spi_responder.sv
// tb_aes_spi_responder: directed checks of aes_spi_responder for Nk=4 and Nk=8.
module tb_aes_spi_responder;
  logic clk, rst, cs, sdi, cdone, sel;
  logic [127:0] cres;
  logic sdo4, st4, busy4, rd4, fe4, sdo8, st8, busy8, rd8, fe8;
  logic [127:0] data4, data8, key4;
  logic [255:0] key8;
  logic sdo, start, busy, rdone, ferr;
  logic [127:0] cdata;
  logic [255:0] ckey;
  int compared = 0, mism = 0;
  localparam logic [127:0] FD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FR = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] D2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] R2 = 128'hdeadbeef0123456789abcdeffedcba98;

  aes_spi_responder #(.Nk(4)) dut (.clk(clk), .rst(rst), .CS(cs), .SDI(sdi), .SDO(sdo4),
    .core_start(st4), .core_data(data4), .core_key(key4), .core_done(cdone),
    .core_result(cres), .busy(busy4), .resp_done(rd4), .frame_err(fe4));
  aes_spi_responder #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .CS(cs), .SDI(sdi), .SDO(sdo8),
    .core_start(st8), .core_data(data8), .core_key(key8), .core_done(cdone),
    .core_result(cres), .busy(busy8), .resp_done(rd8), .frame_err(fe8));

  assign sdo = sel ? sdo8 : sdo4;
  assign start = sel ? st8 : st4;
  assign busy = sel ? busy8 : busy4;
  assign rdone = sel ? rd8 : rd4;
  assign ferr = sel ? fe8 : fe4;
  assign cdata = sel ? data8 : data4;
  assign ckey = sel ? key8 : {128'b0, key4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [383:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      cs = 1'b1;
      if (i == 0) check("pre_start", start, 0);
      tick();
    end
    sdi = 1'b0;
  endtask

  task automatic do_tx(input logic [127:0] r, output logic [127:0] got);
    cdone = 1'b1;
    cres = r;
    tick();
    cdone = 1'b0;
    cres = '0;
`ifdef AES_SPI_RESP_START_BIT_EN
    check("marker", sdo, 1);
    tick();
`endif
    for (int k = 0; k < 128; k++) begin
      got[127-k] = sdo;
      tick();
    end
  endtask

  task automatic full(input logic [127:0] d, input logic [255:0] k, input int n,
                      input logic [127:0] r, input string tag);
    logic [383:0] v;
    logic [127:0] got;
    v = (n == 256) ? {128'b0, d, k[127:0]} : {d, k};
    send_frame(v, n);
    check({tag, ":core_start"}, start, 1);
    check({tag, ":core_data"}, cdata, d);
    check({tag, ":core_key"}, ckey, k);
    tick();
    check({tag, ":start_one_cycle"}, start, 0);
    check({tag, ":busy_wait"}, busy, 1);
    repeat (11) tick();
    do_tx(r, got);
    check({tag, ":sdo_stream"}, got, r);
    check({tag, ":resp_done"}, rdone, 1);
    check({tag, ":sdo_done"}, sdo, 0);
    tick();
    check({tag, ":resp_done_once"}, rdone, 0);
    check({tag, ":busy_hold"}, busy, 1);
  endtask

  initial begin
    logic [127:0] got;
    sel = 1'b0;
    rst = 1'b1;
    cs = 1'b0;
    sdi = 1'b0;
    cdone = 1'b0;
    cres = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_sdo", sdo, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_done", rdone, 0);
    check("rst_frame_err", ferr, 0);
    check("rst_core_data", cdata, 0);
    check("rst_core_key", ckey, 0);

    full(FD, {128'b0, FK}, 256, FR, "fips4");

    // CS kept high in HOLD must not open a new frame
    sdi = 1'b1;
    repeat (6) tick();
    check("hold_busy", busy, 1);
    check("hold_no_start", start, 0);
    check("hold_sdo", sdo, 0);
    check("hold_data", cdata, FD);
    cs = 1'b0;
    sdi = 1'b0;
    tick();
    check("hold_exit_idle", busy, 0);

    cs = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sdi = i[0];
      tick();
    end
    cs = 1'b0;
    tick();
    check("abort_frame_err", ferr, 1);
    check("abort_busy", busy, 0);
    check("abort_no_start", start, 0);
    check("abort_data_kept", cdata, FD);
    check("abort_key_kept", ckey, {128'b0, FK});
    tick();
    check("abort_err_pulse", ferr, 0);

    send_frame({128'b0, D2, K2}, 256);
    check("early_done:start", start, 1);
    check("early_done:data", cdata, D2);
    cdone = 1'b1;
    cres = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    tick();
    cdone = 1'b0;
    cres = '0;
    check("early_done:sdo_wait", sdo, 0);
    check("early_done:busy", busy, 1);
    repeat (4) tick();
    check("early_done:still_wait", sdo, 0);
    do_tx(R2, got);
    check("early_done:stream", got, R2);
    check("early_done:resp_done", rdone, 1);
    tick();
    cs = 1'b0;
    tick();
    check("early_done:idle", busy, 0);

    send_frame({128'b0, FD, FK}, 256);
    tick();
    cdone = 1'b1;
    cres = FR;
    tick();
    cdone = 1'b0;
    cres = '0;
`ifdef AES_SPI_RESP_START_BIT_EN
    tick();
`endif
    repeat (60) tick();
    check("midtx_bit60", sdo, FR[67]);
    rst = 1'b1;
    cs = 1'b0;
    tick();
    check("midtx_rst_sdo", sdo, 0);
    check("midtx_rst_busy", busy, 0);
    check("midtx_rst_data", cdata, 0);
    check("midtx_rst_resp_done", rdone, 0);
    rst = 1'b0;
    tick();
    full(FD, {128'b0, FK}, 256, FR, "after_rst");
    cs = 1'b0;
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    sel = 1'b1;
    tick();
    check("nk8_idle", busy, 0);
    full(FD, K8, 384, R8, "nk8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
